// File: rtl/shift_add_mult10.sv
// Sequential unsigned N x N multiplier: one shared 10-bit ripple adder is
// reused over N shift-and-add iterations behind a start/busy/done handshake.

module rippleAdder (
    input  logic [9:0] A10,
    input  logic [9:0] B10,
    input  logic       Cin_,
    output logic [9:0] Sum10,
    output logic       Cout_
);
    logic [10:0] w_c;

    always_comb begin
        w_c    = '0;
        Sum10  = '0;
        w_c[0] = Cin_;
        for (int i = 0; i < 10; i++) begin
            Sum10[i]  = A10[i] ^ B10[i] ^ w_c[i];
            w_c[i+1]  = (A10[i] & B10[i]) | (w_c[i] & (A10[i] ^ B10[i]));
        end
        Cout_ = w_c[10];
    end
endmodule

// state  | meaning
// IDLE   | waiting for start, operands not yet captured
// CALC   | one shift-and-add iteration per cycle, N cycles
// DONE   | result registered, done pulses for one cycle
module shift_add_mult10 #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Product,
    output logic           busy,
    output logic           done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [N-1:0]   r_m;
    logic [2*N-1:0] r_p;
    logic [3:0]     r_cnt;
    logic [2*N-1:0] r_product;

    logic [N-1:0]   w_b10;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic [2*N-1:0] w_shift;

    assign w_b10 = r_p[0] ? r_m : '0;

    rippleAdder u_adder (
        .A10   (r_p[2*N-1:N]),
        .B10   (w_b10),
        .Cin_  (1'b0),
        .Sum10 (w_sum),
        .Cout_ (w_cout)
    );

    // Carry lands in the top bit, so the accumulator never overflows.
    assign w_shift = {w_cout, w_sum, r_p[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= A;
                        r_p     <= {{N{1'b0}}, B};
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_p   <= w_shift;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(N - 1)) begin
                        r_product <= w_shift;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Product = r_product;
    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
endmodule

// File: tb/tb_shift_add_mult10.sv
// Directed and held-start random checks for shift_add_mult10.

module tb_shift_add_mult10;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  A;
    logic [9:0]  B;
    logic [19:0] Product;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    shift_add_mult10 #(.N(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; scrambles A/B after capture.
    task automatic do_mult(input logic [9:0] a, input logic [9:0] b,
                           input logic [19:0] exp, input string tag);
        int nbusy;
        int ndone;
        nbusy = 0;
        ndone = 0;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a;
        B = ~b;
        repeat (10) begin
            if (busy) nbusy++;
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, nbusy, 10);
        chk({tag, "_early_done"}, ndone, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_product"}, Product, exp);
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_hold"}, Product, exp);
    endtask

    initial begin
        int nd;
        logic [9:0]  cur_a;
        logic [9:0]  cur_b;
        logic [19:0] last_prod;
        int          last_cyc;
        bit          got;
        bit          stable;

        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", Product, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_mult(10'd5, 10'd7, 20'h00023, "m5x7");
        do_mult(10'h3FF, 10'h3FF, 20'hFF801, "mmax");
        do_mult(10'h000, 10'h2A5, 20'h00000, "mzero");
        do_mult(10'h200, 10'h200, 20'h40000, "mpow2");

        // start during CALC must be ignored
        A = 10'd3;
        B = 10'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
            if (i == 4) begin
                A = 10'd9;
                B = 10'd9;
                start = 1'b1;
            end
            if (i == 5) start = 1'b0;
        end
        chk("ign_done_count", nd, 1);
        chk("ign_product", Product, 12);
        chk("ign_busy", busy, 0);

        // async reset mid-CALC
        A = 10'h3FF;
        B = 10'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_product", Product, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_mult(10'd6, 10'd6, 20'd36, "m6x6");

        // held start, back-to-back random operations
        cur_a = 10'($urandom);
        cur_b = 10'($urandom);
        A = cur_a;
        B = cur_b;
        start = 1'b1;
        last_prod = Product;
        last_cyc = 0;
        for (int k = 0; k < 1000; k++) begin
            got = 1'b0;
            stable = 1'b1;
            for (int w = 0; w < 20 && !got; w++) begin
                @(posedge clk); #1;
                if (done) got = 1'b1;
                else if (Product !== last_prod) stable = 1'b0;
            end
            if (!got) begin
                chk("rnd_done_timeout", 0, 1);
                break;
            end
            chk("rnd_product", Product, 20'(cur_a) * 20'(cur_b));
            if (k > 0) begin
                chk("rnd_spacing", cyc - last_cyc, 12);
                chk("rnd_stable", stable, 1);
            end
            last_cyc = cyc;
            last_prod = Product;
            cur_a = 10'($urandom);
            cur_b = 10'($urandom);
            A = cur_a;
            B = cur_b;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
